// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the SDF FFT output.
// Two ping-pong banks of N complex words: the writer fills one bank in
// bit-reversed address order while the reader drains the other bank in
// natural order into a single output register with valid/ready.
module fft_bitrev_reorder #(
    parameter int WIDTH  = 16,
    parameter int N_LOG2 = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_last
);

    localparam int N = 2 ** N_LOG2;

    typedef logic [N_LOG2-1:0]  idx_t;
    typedef logic [2*WIDTH-1:0] word_t;

    // Reverse the N_LOG2 index bits: bit-reversed arrival index -> natural bin.
    function automatic idx_t bitrev(input idx_t a);
        idx_t r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = a[N_LOG2-1-i];
        end
        return r;
    endfunction

    // Bank b occupies addresses {b, idx}.
    word_t mem [2*N];

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    idx_t             wr_cnt_q, wr_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    idx_t             rd_cnt_q, rd_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_re_q, out_re_d;
    logic [WIDTH-1:0] out_im_q, out_im_d;

    logic  wr_fire;
    logic  rd_load;
    word_t rd_word;

    // Accept only into a bank the reader has released; depends on registers only.
    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid && in_ready;
    assign rd_load  = full_q[rd_bank_q] && (!out_valid_q || out_ready);
    assign rd_word  = mem[{rd_bank_q, rd_cnt_q}];

    // Sample store: scatter each arriving sample to its natural-order slot.
    // NOTE: the storage array has no reset; stale words are never read because
    // a bank is only read after it has been completely rewritten.
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            mem[{wr_bank_q, bitrev(wr_cnt_q)}] <= {in_re, in_im};
        end
    end

    // Next-state: write counter/bank, read counter/bank, full flags, output register.
    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned,
        // which would otherwise infer a latch.
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + idx_t'(1);
            if (&wr_cnt_q) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // The writer only sets a non-full bank and the reader only clears a
        // full one, so these two updates never target the same flag.
        if (rd_load) begin
            out_re_d    = rd_word[2*WIDTH-1:WIDTH];
            out_im_d    = rd_word[WIDTH-1:0];
            out_last_d  = &rd_cnt_q;
            out_valid_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + idx_t'(1);
            if (&rd_cnt_q) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // State register with synchronous reset; bank contents are left untouched.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at N=8: frames are sent in
// bit-reversed order and the natural-order output stream is compared
// against hand-tabulated expected samples.
module tb_fft_bitrev_reorder;

    localparam int WIDTH  = 16;
    localparam int N_LOG2 = 3;
    localparam int N      = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_re = '0;
    logic [WIDTH-1:0] in_im = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_re;
    logic [WIDTH-1:0] out_im;
    logic             out_last;

    fft_bitrev_reorder #(.WIDTH(WIDTH), .N_LOG2(N_LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Arrival position k carries natural bin br_tab[k] (3-bit reversal, by hand).
    int br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [31:0] src_q [$];
    logic [32:0] exp_q [$];
    bit          src_en = 1'b0;
    bit          snk_en = 1'b0;
    bit          rnd    = 1'b0;
    int          cyc = 0, in_acc = 0, out_acc = 0, extra_cnt = 0;
    int          checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    // mode 0: re = base+bin, im = -re; mode 1: alternating full-scale extremes.
    function automatic logic [31:0] sample_val(input int base, input int mode, input int bin);
        logic [15:0] re, im;
        if (mode == 0) begin
            re = 16'(base + bin);
            im = -re;
        end else begin
            re = bin[0] ? 16'h7fff : 16'h8000;
            im = bin[0] ? 16'h8000 : 16'h7fff;
        end
        return {re, im};
    endfunction

    task automatic push_frame(input int base, input int mode, input int nsamp);
        for (int k = 0; k < nsamp; k++) begin
            src_q.push_back(sample_val(base, mode, br_tab[k]));
        end
        if (nsamp == N) begin
            for (int j = 0; j < N; j++) begin
                exp_q.push_back({(j == N - 1), sample_val(base, mode, j)});
            end
        end
    endtask

    // One clock: drive inputs, resolve both handshakes, score output, advance.
    task automatic tick();
        bit          inf, outf;
        logic [32:0] e;
        if (rnd) begin
            src_en = ($urandom_range(0, 3) != 0);
            snk_en = ($urandom_range(0, 1) == 1);
        end
        in_valid  = src_en && (src_q.size() > 0);
        if (in_valid) {in_re, in_im} = src_q[0];
        out_ready = snk_en;
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        if (inf) begin
            void'(src_q.pop_front());
            in_acc++;
        end
        if (outf) begin
            out_acc++;
            if (exp_q.size() == 0) begin
                extra_cnt++;
            end else begin
                e = exp_q.pop_front();
                check($sformatf("out_%0d", out_acc), 64'({out_last, out_re, out_im}), 64'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(src_q.size() + exp_q.size()), 64'(0));
    endtask

    initial begin
        int n, stall, first, last, held_bad, acc0;

        // Reset state.
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_re", 64'(out_re), 64'(0));
        check("rst_out_im", 64'(out_im), 64'(0));

        // Single frame 0,4,2,6,1,5,3,7 -> 0..7; first out_valid one edge after last input.
        src_en = 1'b1;
        snk_en = 1'b1;
        push_frame(0, 0, N);
        n = 0;
        while (src_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        check("lat_before", 64'(out_valid), 64'(0));
        tick();
        check("lat_after", 64'(out_valid), 64'(1));
        check("lat_bin0", 64'(out_re), 64'(0));
        drain("single", 50);

        // Three back-to-back frames: no input stall, 24 contiguous outputs.
        push_frame(16, 0, N);
        push_frame(32, 0, N);
        push_frame(48, 0, N);
        stall = 0; first = -1; last = -1; n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < 100) begin
            if (!in_ready && src_q.size() > 0) stall++;
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            tick();
            n++;
        end
        check("b2b_stall", 64'(stall), 64'(0));
        check("b2b_span", 64'(last - first + 1), 64'(24));
        check("b2b_drained", 64'(src_q.size() + exp_q.size()), 64'(0));

        // Output stalled while two frames arrive: backpressure and hold.
        snk_en = 1'b0;
        acc0 = in_acc;
        push_frame(64, 0, N);
        push_frame(72, 0, N);
        held_bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (out_valid && (out_re != 16'd64 || out_im != 16'hffc0 || out_last)) held_bad++;
            tick();
        end
        check("bp_accepted", 64'(in_acc - acc0), 64'(16));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_hold_re", 64'(out_re), 64'(64));
        check("bp_hold_im", 64'(out_im), 64'(16'hffc0));
        check("bp_hold_last", 64'(out_last), 64'(0));
        check("bp_hold_steady", 64'(held_bad), 64'(0));
        snk_en = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("bp_release_ready", 64'(in_ready), 64'(1));
        check("bp_release_bin", 64'(out_re), 64'(71));
        check("bp_release_last", 64'(out_last), 64'(1));
        drain("bp", 50);

        // Random valid/ready toggling over ten frames.
        for (int f = 0; f < 10; f++) push_frame(100 + 8 * f, 0, N);
        rnd = 1'b1;
        drain("rand", 2000);
        rnd = 1'b0;
        src_en = 1'b1;
        snk_en = 1'b1;

        // Reset with one frame mid-output and a partial frame mid-input.
        snk_en = 1'b0;
        push_frame(200, 0, N);
        n = 0;
        while (src_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        snk_en = 1'b1;
        tick();
        tick();
        snk_en = 1'b0;
        push_frame(300, 0, 5);
        n = 0;
        while (src_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_out_last", 64'(out_last), 64'(0));
        exp_q.delete();
        src_q.delete();
        snk_en = 1'b1;
        push_frame(400, 0, N);
        drain("post_rst", 60);

        // Full-scale extremes pass bit-exact.
        push_frame(0, 1, N);
        drain("extreme", 60);

        repeat (5) tick();
        check("no_extra", 64'(extra_cnt), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
